// File: rtl/neuron_pkg.sv
// neuron_pkg: shared state encoding and saturation limits for the neuron accumulator
package neuron_pkg;
    typedef enum logic [1:0] {IDLE, ACCUM, DONE} acc_state_t;
    function automatic longint sat_max(input int w);
        return (longint'(1) <<< (w - 1)) - 1;
    endfunction
    function automatic longint sat_min(input int w);
        return -(longint'(1) <<< (w - 1));
    endfunction
endpackage

// File: rtl/neuron_accumulator_sat_add.sv
// sat_add: signed ACC_W + IN_W add with overflow flag and optional saturation
module sat_add
    import neuron_pkg::*;
#(
    parameter int ACC_W = 16,
    parameter int IN_W = 8,
    parameter bit SAT_EN = 1'b1
) (
    input  logic signed [ACC_W-1:0] a,
    input  logic signed [IN_W-1:0]  b,
    output logic signed [ACC_W-1:0] sum,
    output logic                    ovf
);
    localparam logic signed [ACC_W-1:0] MAX_V = ACC_W'(sat_max(ACC_W));
    localparam logic signed [ACC_W-1:0] MIN_V = ACC_W'(sat_min(ACC_W));
    logic signed [ACC_W:0] full;
    assign full = {a[ACC_W-1], a} + {{(ACC_W + 1 - IN_W){b[IN_W-1]}}, b};
    assign ovf = full[ACC_W] != full[ACC_W-1];
    assign sum = (ovf && SAT_EN) ? (full[ACC_W] ? MIN_V : MAX_V) : full[ACC_W-1:0];
endmodule

// File: rtl/neuron_accumulator.sv
// neuron_accumulator: handshaked bias-plus-samples accumulator producing one signed sum per transaction
module neuron_accumulator
    import neuron_pkg::*;
#(
    parameter int ACC_W = 16,
    parameter int IN_W = 8,
    parameter int N_MAX = 16,
    parameter bit SAT_EN = 1'b1,
    localparam int LEN_W = $clog2(N_MAX + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic signed [ACC_W-1:0] bias,
    input  logic [LEN_W-1:0]        len,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [IN_W-1:0]  in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [ACC_W-1:0] out_sum,
    output logic                    out_ovf,
    output logic                    busy
);
    localparam logic [LEN_W-1:0] N_MAX_L = LEN_W'(N_MAX);
    if (ACC_W <= IN_W || N_MAX < 1) begin : g_param_chk
        $error("neuron_accumulator: need ACC_W > IN_W and N_MAX >= 1");
    end
    acc_state_t state;
    logic signed [ACC_W-1:0] acc, add_sum;
    logic [LEN_W-1:0] cnt, len_c;
    logic ovf, add_ovf;
    assign len_c = (len > N_MAX_L) ? N_MAX_L : len;
    assign out_sum = acc;
    assign out_ovf = ovf;
    sat_add #(.ACC_W(ACC_W), .IN_W(IN_W), .SAT_EN(SAT_EN)) u_add (
        .a(acc), .b(in_data), .sum(add_sum), .ovf(add_ovf)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            acc <= '0;
            cnt <= '0;
            ovf <= 1'b0;
            in_ready <= 1'b0;
            out_valid <= 1'b0;
            busy <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    acc <= bias;
                    cnt <= len_c;
                    ovf <= 1'b0;
                    busy <= 1'b1;
                    state <= (len_c == '0) ? DONE : ACCUM;
                    in_ready <= len_c != '0;
                    out_valid <= len_c == '0;
                end
                ACCUM: if (in_valid) begin
                    acc <= add_sum;
                    ovf <= ovf | add_ovf;
                    cnt <= cnt - LEN_W'(1);
                    if (cnt == LEN_W'(1)) begin
                        state <= DONE;
                        in_ready <= 1'b0;
                        out_valid <= 1'b1;
                    end
                end
                DONE: if (out_ready) begin
                    state <= IDLE;
                    out_valid <= 1'b0;
                    busy <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_neuron_accumulator.sv
// tb_neuron_accumulator: directed + random transactions on saturating and wrapping instances vs an integer model
module tb_neuron_accumulator;
    localparam int MAXV = 32767;
    localparam int MINV = -32768;
    localparam int NMAX = 16;
    logic clk = 1'b0, rst = 1'b1, start = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic signed [15:0] bias = '0;
    logic [4:0] len = '0;
    logic signed [7:0] in_data = '0;
    logic s_in_ready, s_out_valid, s_out_ovf, s_busy;
    logic w_in_ready, w_out_valid, w_out_ovf, w_busy;
    logic signed [15:0] s_out_sum, w_out_sum;
    int errors = 0, checks = 0;
    int smp[$];
    always #5 clk = ~clk;
    neuron_accumulator #(.SAT_EN(1'b1)) dut_sat (
        .clk(clk), .rst(rst), .start(start), .bias(bias), .len(len),
        .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_sum(s_out_sum),
        .out_ovf(s_out_ovf), .busy(s_busy)
    );
    neuron_accumulator #(.SAT_EN(1'b0)) dut_wrap (
        .clk(clk), .rst(rst), .start(start), .bias(bias), .len(len),
        .in_valid(in_valid), .in_ready(w_in_ready), .in_data(in_data),
        .out_valid(w_out_valid), .out_ready(out_ready), .out_sum(w_out_sum),
        .out_ovf(w_out_ovf), .busy(w_busy)
    );
    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    function automatic void model(input int b, input int n, input bit sat, output int s, output bit o);
        s = b;
        o = 1'b0;
        for (int i = 0; i < n; i++) begin
            int t;
            t = s + smp[i];
            if (t > MAXV || t < MINV) begin
                o = 1'b1;
                t = sat ? ((t > MAXV) ? MAXV : MINV) : ((t > MAXV) ? t - 65536 : t + 65536);
            end
            s = t;
        end
    endfunction
    task automatic txn(input int b, input int l, input bit toggle, input int hold);
        int n, idx, cyc, es, ew;
        bit eo_s, eo_w;
        n = (l > NMAX) ? NMAX : l;
        model(b, n, 1'b1, es, eo_s);
        model(b, n, 1'b0, ew, eo_w);
        bias = 16'(b);
        len = 5'(l);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_after_start", s_busy, 1);
        check("in_ready_after_start", s_in_ready, n != 0);
        idx = 0;
        cyc = 0;
        while (idx < n && cyc < 200) begin
            check("in_ready_accum", s_in_ready, 1);
            in_valid = toggle ? (cyc % 2 == 0) : 1'b1;
            in_data = 8'(smp[idx]);
            tick();
            if (in_valid) idx++;
            cyc++;
        end
        in_valid = 1'b0;
        check("samples_accepted", idx, n);
        check("out_valid_sat", s_out_valid, 1);
        check("out_valid_wrap", w_out_valid, 1);
        check("in_ready_done", s_in_ready, 0);
        check("sum_sat", s_out_sum, es);
        check("ovf_sat", s_out_ovf, eo_s);
        check("sum_wrap", w_out_sum, ew);
        check("ovf_wrap", w_out_ovf, eo_w);
        for (int i = 0; i < hold; i++) begin
            start = 1'b1;
            bias = 16'(b + 1);
            len = 5'd1;
            tick();
            check("hold_valid", s_out_valid, 1);
            check("hold_sum", s_out_sum, es);
            check("hold_ovf", s_out_ovf, eo_s);
        end
        start = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("released_valid", s_out_valid, 0);
        check("released_busy", s_busy, 0);
        check("released_in_ready", s_in_ready, 0);
        tick();
        check("idle_stays", s_busy, 0);
    endtask
    initial begin
        tick();
        tick();
        check("rst_in_ready", s_in_ready, 0);
        check("rst_out_valid", s_out_valid, 0);
        check("rst_out_sum", s_out_sum, 0);
        check("rst_out_ovf", s_out_ovf, 0);
        check("rst_busy", s_busy, 0);
        rst = 1'b0;
        tick();
        smp = '{10, -20, 5};
        txn(100, 3, 1'b0, 0);
        smp = '{127, -1};
        txn(32760, 2, 1'b0, 0);
        smp = '{1};
        txn(32767, 1, 1'b0, 0);
        smp = '{-128, -128, 127, -5};
        txn(-32700, 4, 1'b1, 5);
        smp = '{};
        txn(-7, 0, 1'b0, 0);
        smp = '{};
        for (int i = 0; i < NMAX + 1; i++) smp.push_back(100 + i);
        txn(-1000, NMAX + 1, 1'b0, 0);
        smp = '{3, 4, 5, 6};
        bias = 16'sd50;
        len = 5'd4;
        start = 1'b1;
        tick();
        start = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_data = 8'(smp[i]);
            tick();
        end
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        check("midrst_in_ready", s_in_ready, 0);
        check("midrst_out_valid", s_out_valid, 0);
        check("midrst_out_sum", s_out_sum, 0);
        check("midrst_out_ovf", s_out_ovf, 0);
        check("midrst_busy", s_busy, 0);
        rst = 1'b0;
        tick();
        smp = '{-128};
        txn(0, 1, 1'b0, 0);
        for (int k = 0; k < 12; k++) begin
            int l;
            l = int'($urandom_range(0, NMAX + 1));
            smp = '{};
            for (int i = 0; i < l; i++) smp.push_back(int'($urandom_range(0, 255)) - 128);
            txn(int'($urandom_range(0, 65535)) - 32768, l, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/neuron_accumulator.md
# neuron_accumulator

Parametrised, handshaked successor to the single-cycle registered adder: it accumulates a programmable-length stream of signed input samples onto a bias value and emits one signed neuron pre-activation sum per transaction. The adder is widened to ACC_W-bit accumulator / IN_W-bit operands. Overflow can saturate or wrap, selected at elaboration. It sits between the weighted-input multiplier stage and the activation stage of the neuron datapath.

## Interface
- ACC_W, 16, accumulator and bias width (signed); must satisfy ACC_W > IN_W
- IN_W, 8, input sample width (signed)
- N_MAX, 16, maximum samples per transaction
- SAT_EN, 1, 1 = saturate on overflow, 0 = two's-complement wrap
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin transaction; sampled only in IDLE
- bias  in  ACC_W  signed initial accumulator value, captured on start
- len  in  $clog2(N_MAX+1)  sample count, captured on start; values > N_MAX are clamped to N_MAX
- in_valid  in  1  input sample valid
- in_ready  out  1  block accepts a sample
- in_data  in  IN_W  signed input sample
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts the result
- out_sum  out  ACC_W  signed accumulated result
- out_ovf  out  1  sticky: at least one add in this transaction overflowed
- busy  out  1  state != IDLE

## Operation
- FSM states: IDLE, ACCUM, DONE.
- IDLE:
  - start=1 → acc←bias, cnt←min(len,N_MAX), ovf←0.
  - Next state is ACCUM, or DONE if the captured count is 0.
- ACCUM:
  - in_ready=1.
  - Each cycle with in_valid=1 applies acc←acc+sext(in_data) and cnt←cnt−1.
  - Accepting the sample when cnt==1 moves the FSM to DONE.
  - in_valid=0 stalls with no state change.
- DONE:
  - out_valid=1; out_sum=acc; out_ovf=ovf.
  - Values are held stable until out_ready=1, which moves the FSM to IDLE.
- Arithmetic:
  - Sum is computed at ACC_W+1 bits.
  - Overflow occurs when bit ACC_W ≠ bit ACC_W−1.
  - SAT_EN=1: result clamps to 2^(ACC_W−1)−1 or −2^(ACC_W−1).
  - SAT_EN=0: result keeps the low ACC_W bits.
  - Either mode sets ovf.
- Saturation is applied per add, not only at the end. A later add may move a saturated value back into range, and ovf stays set.
- start outside IDLE is ignored and is not queued.
- rst in any state: FSM→IDLE; acc, cnt and ovf cleared; any in-flight transaction is discarded with no output.

## Timing
- Reset values: in_ready=0, out_valid=0, out_sum=0, out_ovf=0, busy=0.
- start at edge t → busy=1 and in_ready=1 from t+1.
- Each accepted sample costs 1 cycle.
- Last sample accepted at edge k → out_valid=1 from k+1.
- len=0: start at t → out_valid at t+1 with out_sum=bias.
- Result is released on the edge where out_valid&out_ready are both 1; IDLE follows on the next cycle.
- Best-case transaction length is len+2 cycles start-to-start.
- in_ready and out_valid are pure functions of state (registered), with no combinational path from in_valid or out_ready.

## Structure
- Shared package neuron_pkg:
  - state enum acc_state_t {IDLE, ACCUM, DONE}
  - sat_max/sat_min constant functions of width
- Sub-module sat_add (combinational):
  - inputs a[ACC_W], b[IN_W], parameter SAT_EN
  - outputs sum[ACC_W], ovf
  - neuron_accumulator instantiates it once.
- Elaboration assertion: ACC_W > IN_W, N_MAX ≥ 1.

## Test plan
- Basic accumulate (defaults): bias=100, len=3, samples 10, −20, 5 → out_sum=95, out_ovf=0, out_valid at 1 cycle after third accept.
- Positive saturation (SAT_EN=1): bias=32760, len=2, samples 127, −1 → out_sum=32766, out_ovf=1. The first add clamps to 32767, then −1 gives 32766.
- Wrap mode (SAT_EN=0): bias=32767, len=1, sample 1 → out_sum=−32768, out_ovf=1.
- Handshake stalls:
  - in_valid toggled 1/0 every cycle, len=4 → exactly 4 samples summed.
  - out_ready held 0 for 5 cycles → out_sum/out_valid stable and start ignored.
  - Then out_ready=1 → IDLE on the next cycle.
- Boundary len:
  - len=0, bias=−7 → out_sum=−7 one cycle after start.
  - len=N_MAX+1 → clamped, exactly N_MAX samples consumed.
- Reset mid-transaction: rst after 2 of 4 samples → all outputs at reset values next cycle. A new transaction then (bias=0, len=1, sample −128) yields out_sum=−128, out_ovf=0.
